// File: rtl/keypad_pkg.sv
// Shared state encoding, special key codes and the row/column key map
// for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Physical layout: row r, column c -> hex code printed on the key.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'h0;
            4'hE: code = KEY_HASH;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Rows are active-low; the lowest-indexed low row wins.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows_n);
        logic [1:0] idx;
        if (!rows_n[0])      idx = 2'd0;
        else if (!rows_n[1]) idx = 2'd1;
        else if (!rows_n[2]) idx = 2'd2;
        else                 idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick.sv
// Free-running scan-tick divider: one-clock pulse every 2^SCAN_EXP clocks.
module keypad_tick #(
    parameter int SCAN_EXP = 17
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    logic [SCAN_EXP-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_q + SCAN_EXP'(1);
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row sync, press/release debounce,
// hex key code with valid strobe and a two-digit BCD entry register.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_EXP = 17,
    parameter int DEB_CNT  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [7:0] entry_bcd
);
    localparam logic [4:0] DEB = 5'(DEB_CNT);

    logic [3:0] sync_q, rs_q;
    logic       tick;
    kp_state_e  state_q, state_d;
    logic [1:0] ci_q, ci_d;
    logic [1:0] ri_q, ri_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic [7:0] entry_q, entry_d;
    logic [4:0] cnt_inc;
    logic       at_deb;
    logic       row_low;
    logic       accept;

    keypad_tick #(.SCAN_EXP(SCAN_EXP)) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Rows idle high, so the synchronizer resets to all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 4'hF;
            rs_q   <= 4'hF;
        end else begin
            sync_q <= row_in;
            rs_q   <= sync_q;
        end
    end

    assign cnt_inc = {1'b0, cnt_q} + 5'd1;
    assign at_deb  = (cnt_inc >= DEB);
    assign row_low = ~rs_q[ri_q];

    always_comb begin
        state_d = state_q;
        ci_d    = ci_q;
        ri_d    = ri_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        entry_d = entry_q;
        valid_d = 1'b0;
        accept  = 1'b0;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (rs_q != 4'hF) begin
                        ri_d  = lowest_low(rs_q);
                        cnt_d = 4'd1;
                        if (DEB_CNT <= 1) accept  = 1'b1;
                        else              state_d = DEBOUNCE;
                    end else begin
                        ci_d = ci_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_low) begin
                        cnt_d = cnt_inc[3:0];
                        if (at_deb) accept = 1'b1;
                    end else begin
                        state_d = SCAN;
                        ci_d    = ci_q + 2'd1;
                    end
                end
                HELD: begin
                    if (!row_low) begin
                        if (DEB_CNT <= 1) begin
                            state_d = SCAN;
                            ci_d    = ci_q + 2'd1;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (!row_low) begin
                        if (at_deb) begin
                            state_d = SCAN;
                            ci_d    = ci_q + 2'd1;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_inc[3:0];
                        end
                    end else begin
                        // Bounce back to pressed: no second strobe for the same key.
                        state_d = HELD;
                        cnt_d   = 4'd0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        if (accept) begin
            state_d = HELD;
            valid_d = 1'b1;
            code_d  = key_map(ri_d, ci_q);
            if (code_d <= 4'd9)          entry_d = {entry_q[3:0], code_d};
            else if (code_d == KEY_STAR) entry_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SCAN;
            ci_q    <= 2'd0;
            ri_q    <= 2'd0;
            cnt_q   <= 4'd0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            entry_q <= 8'h00;
        end else begin
            state_q <= state_d;
            ci_q    <= ci_d;
            ri_q    <= ri_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign col_out   = ~(4'b0001 << ci_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = (state_q == HELD) || (state_q == RELEASE);
    assign entry_bcd = entry_q;

endmodule

// File: doc/keypad_scan.md
# keypad_scan

4x4 matrix keypad scanner and debouncer, the input-side counterpart of the multiplexed 7-segment display path. It drives one keypad column low at a time, samples the active-low rows, debounces press and release, and emits a hex key code with a one-clock valid strobe. It also keeps a two-digit BCD entry register that feeds the existing BCD-to-segment display path directly.

## Interface
- SCAN_EXP, 17: scan tick period is 2^SCAN_EXP clocks.
- DEB_CNT, 4: consecutive stable scan ticks required to accept a press or a release; range 1..15.
- clk  in  1  system clock; the single clock domain.
- reset  in  1  asynchronous, active-low reset.
- row_in  in  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
- col_out  out  4  column drive, active-low, exactly one bit low at all times.
- key_code  out  4  hex code of the last accepted key.
- key_valid  out  1  one-clock pulse when a press is accepted.
- key_held  out  1  high while an accepted key has not yet been released.
- entry_bcd  out  8  two BCD digits {tens, ones} of the keyed entry.

## Operation
- row_in passes through a 2-flop synchronizer; all decisions use the synchronized value `rs`.
- The tick counter is SCAN_EXP bits wide and free-running. `tick` is a one-clock pulse when the counter equals all-ones.
- Column index `ci` ranges 0..3. col_out = ~(4'b0001 << ci).
- The state machine has four states: SCAN, DEBOUNCE, HELD, RELEASE. Every transition happens only on a tick.
  - SCAN:
    - If any rs bit is low, capture `ri` as the lowest-indexed low row, hold `ci`, set cnt=1, and go to DEBOUNCE.
    - Otherwise advance ci, wrapping 3 to 0.
  - DEBOUNCE:
    - If rs[ri] is low, increment cnt. When the incremented cnt would reach DEB_CNT, pulse key_valid, load key_code, and go to HELD.
    - If rs[ri] is high, go to SCAN and advance ci.
    - With DEB_CNT=1, SCAN goes straight to HELD and pulses key_valid.
  - HELD:
    - key_held=1. ci stays frozen.
    - If rs[ri] is high, set cnt=1 and go to RELEASE.
  - RELEASE:
    - If rs[ri] is high, increment cnt. At DEB_CNT, go to SCAN and advance ci.
    - If rs[ri] is low, go to HELD and clear cnt. No new key_valid is issued.
- Key code map, written as row: col0 col1 col2 col3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 F(#) D
- Entry register, updated on the same edge that raises key_valid:
  - Codes 0..9: entry_bcd <= {entry_bcd[3:0], code}. The old tens digit is dropped.
  - Code E: entry_bcd <= 0.
  - All other codes leave entry_bcd unchanged.
- Multiple keys:
  - Several rows low in the scanned column: the lowest row wins.
  - Keys in other columns are ignored until the accepted key has been released.
  - A second key pressed while in HELD produces nothing.

## Timing
- Reset values:
  - col_out=4'b1110 (ci=0).
  - key_code=0, key_valid=0, key_held=0, entry_bcd=8'h00.
  - State SCAN, cnt=0, tick counter=0, synchronizer flops=1.
- Reset asserted mid-operation forces all reset values immediately, with no completion of a pending key_valid.
- rs lags row_in by 2 clocks. A column must be driven for a full tick period before its rows are sampled.
- Press latency: key_valid rises on the DEB_CNT-th consecutive tick at which the row is low, counting the SCAN capture tick. key_valid is high for exactly one clock.
- key_held rises on the same edge as key_valid. It falls on the edge that enters SCAN, i.e. on the DEB_CNT-th consecutive high tick.
- key_code and entry_bcd are stable from the key_valid edge until the next accepted key.
- The tick counter is never reset by FSM activity; only reset clears it.

## Structure
- Package keypad_pkg holds:
  - state encoding: SCAN=0, DEBOUNCE=1, HELD=2, RELEASE=3;
  - KEY_STAR=4'hE and KEY_HASH=4'hF;
  - a function mapping (row, col) to the hex code.
- Sub-module keypad_tick(clk, reset, tick) holds the SCAN_EXP-bit counter and its tick decode. Everything else stays in keypad_scan.

## Test plan
All runs use SCAN_EXP=4 (16-clock tick) and DEB_CNT=3.
- **Reset:** hold reset low, then release with rows all high. col_out cycles 1110→1101→1011→0111→1110, one step per 16 clocks; key_valid never asserts; entry_bcd=00.
- **Clean press of key 5:** hold row1 low while col1 is driven, for 6 ticks.
  - Exactly one key_valid pulse, on the 3rd low tick; key_code=5; entry_bcd=05.
  - key_held stays high until 3 high ticks after release; col_out stays frozen at 1101 throughout.
- **Bounce:** row low for 2 ticks, high for 1 tick, then low steadily. No key_valid from the first burst; exactly one valid after 3 stable low ticks.
- **Entry shift and clear:**
  - Press 7, then 4, then 9: entry_bcd reads 07, then 74, then 49.
  - Press * (r3, c0): entry_bcd=00 and key_code=E.
  - Press A: entry_bcd unchanged.
- **Simultaneous rows:** rows 1 and 2 low together on col2. key_code=6 (lowest row). A later press on col0 while 6 is still held gives no key_valid.
- **Reset mid-debounce:** assert reset while in DEBOUNCE with cnt=2. Outputs immediately take reset values, no key_valid appears, and scanning restarts at col_out=1110.
